aud_i2s_tx: RTL and testbench

- Serialises the 16-bit PCM sample from the playback DSP (`o_dac_data`) onto the codec's I2S data pin `AUD_DACDAT`.
- Sits directly downstream of the DSP, which updates its output once per `daclrck` period.
- Runs entirely on the system clock: the codec's `AUD_BCLK` and `AUD_DACLRCK` are treated as asynchronous inputs, synchronised and edge-detected internally.
- Emits the sample MSB-first with the standard I2S one-bit delay, in the left slot (and optionally the right slot).

---
 rtl/aud_i2s_tx.sv | 135 +++++++++++++
 tb/tb_aud_i2s_tx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/aud_i2s_tx.sv
// I2S transmitter: serialises a PCM sample MSB-first with a one-bit delay, on the system clock.
// Define AUD_I2S_STEREO_DUP_EN to repeat the latched sample in the right slot (default: right slot silent).
module aud_i2s_tx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_bclk,
    input  logic              i_daclrck,
    input  logic [DATA_W-1:0] i_dac_data,
    output logic              o_aud_dacdat,
    output logic              o_sample_ack,
    output logic              o_busy,
    output logic [1:0]        o_dbg_state
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_SHIFT = 2'd2,
        ST_PAD   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] bclk_sync_q, bclk_sync_d;
    logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
    logic                   bclk_hist_q, bclk_hist_d;
    logic                   lrck_hist_q, lrck_hist_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [DATA_W-1:0]      sample_q, sample_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   dacdat_q, dacdat_d;
    logic                   ack_q, ack_d;

    logic bclk_fall, lrck_fall, lrck_rise;

    // Strobes compare the last synchroniser stage against its history flop.
    assign bclk_fall = bclk_hist_q & ~bclk_sync_q[SYNC_STAGES-1];
    assign lrck_fall = lrck_hist_q & ~lrck_sync_q[SYNC_STAGES-1];
    assign lrck_rise = ~lrck_hist_q & lrck_sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            bclk_sync_q <= '0;
            lrck_sync_q <= '0;
            bclk_hist_q <= 1'b0;
            lrck_hist_q <= 1'b0;
            shift_q     <= '0;
            sample_q    <= '0;
            cnt_q       <= '0;
            dacdat_q    <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bclk_sync_q <= bclk_sync_d;
            lrck_sync_q <= lrck_sync_d;
            bclk_hist_q <= bclk_hist_d;
            lrck_hist_q <= lrck_hist_d;
            shift_q     <= shift_d;
            sample_q    <= sample_d;
            cnt_q       <= cnt_d;
            dacdat_q    <= dacdat_d;
            ack_q       <= ack_d;
        end
    end

    always_comb begin
        bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], i_bclk};
        lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], i_daclrck};
        bclk_hist_d = bclk_sync_q[SYNC_STAGES-1];
        lrck_hist_d = lrck_sync_q[SYNC_STAGES-1];
        state_d     = state_q;
        shift_d     = shift_q;
        sample_d    = sample_q;
        cnt_d       = cnt_q;
        dacdat_d    = dacdat_q;
        ack_d       = 1'b0;

        // Slot starts take priority over bit-clock edges and abort any word in flight.
        if (lrck_fall) begin
            dacdat_d = 1'b0;
            if (i_en) begin
                sample_d = i_dac_data;
                shift_d  = i_dac_data;
                ack_d    = 1'b1;
                state_d  = ST_DELAY;
            end else begin
                shift_d = '0;
                state_d = ST_IDLE;
            end
        end else if (lrck_rise) begin
            if (state_q != ST_IDLE) begin
                dacdat_d = 1'b0;
`ifdef AUD_I2S_STEREO_DUP_EN
                shift_d  = sample_q;
                state_d  = ST_DELAY;
`else
                shift_d  = '0;
                state_d  = ST_PAD;
`endif
            end
        end else if (bclk_fall) begin
            case (state_q)
                ST_DELAY: begin
                    dacdat_d = shift_q[DATA_W-1];
                    shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                    cnt_d    = CNT_W'(DATA_W - 1);
                    state_d  = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cnt_q == '0) begin
                        dacdat_d = 1'b0;
                        state_d  = ST_PAD;
                    end else begin
                        dacdat_d = shift_q[DATA_W-1];
                        shift_d  = {shift_q[DATA_W-2:0], 1'b0};
                        cnt_d    = cnt_q - 1'b1;
                    end
                end
                default: dacdat_d = 1'b0;
            endcase
        end
    end

    always_comb begin
        o_aud_dacdat = dacdat_q;
        o_sample_ack = ack_q;
        o_busy       = (state_q == ST_DELAY) || (state_q == ST_SHIFT);
        o_dbg_state  = state_q;
    end
endmodule

// File: tb/tb_aud_i2s_tx.sv
// Directed bench for aud_i2s_tx: drives codec BCLK (i_clk/8) and LRCK, captures DACDAT at each BCLK rise.
module tb_aud_i2s_tx;
    logic        i_clk;
    logic        i_rst;
    logic        i_en;
    logic        i_bclk;
    logic        i_daclrck;
    logic [15:0] i_dac_data;
    logic        o_aud_dacdat;
    logic        o_sample_ack;
    logic        o_busy;
    logic [1:0]  o_dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ack_cnt  = 0;
    int ack_cyc  = 0;
    int fall_cyc = 0;
    int chg_bit  = -1;
    logic [15:0] chg_data;
    logic        chg_en;
    logic        stereo;

    aud_i2s_tx #(.DATA_W(16), .SYNC_STAGES(2)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_en         (i_en),
        .i_bclk       (i_bclk),
        .i_daclrck    (i_daclrck),
        .i_dac_data   (i_dac_data),
        .o_aud_dacdat (o_aud_dacdat),
        .o_sample_ack (o_sample_ack),
        .o_busy       (o_busy),
        .o_dbg_state  (o_dbg_state)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_sample_ack) begin
            ack_cnt = ack_cnt + 1;
            ack_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One codec bit period: BCLK low 4 cycles, high 4 cycles; LRCK changes with the falling edge.
    task automatic drive_bit(input logic lr, output logic d);
        if (i_daclrck && !lr) fall_cyc = cyc;
        i_bclk    = 1'b0;
        i_daclrck = lr;
        repeat (4) @(posedge i_clk);
        #1;
        i_bclk = 1'b1;
        d      = o_aud_dacdat;
        repeat (4) @(posedge i_clk);
        #1;
    endtask

    task automatic run_frame(input int slot, output logic [63:0] l, output logic [63:0] r,
                             output int acks);
        logic d;
        int   a0;
        a0 = ack_cnt;
        l  = '0;
        r  = '0;
        for (int i = 0; i < slot; i++) begin
            if (i == chg_bit) begin
                i_dac_data = chg_data;
                i_en       = chg_en;
            end
            drive_bit(1'b0, d);
            l = {l[62:0], d};
        end
        for (int i = 0; i < slot; i++) begin
            drive_bit(1'b1, d);
            r = {r[62:0], d};
        end
        acks    = ack_cnt - a0;
        chg_bit = -1;
    endtask

    logic [63:0] l, r, exp_a5, exp_short;
    logic        d, acc;
    int          acks, a0;

    initial begin
`ifdef AUD_I2S_STEREO_DUP_EN
        stereo = 1'b1;
`else
        stereo = 1'b0;
`endif
        i_rst      = 1'b1;
        i_en       = 1'b1;
        i_bclk     = 1'b1;
        i_daclrck  = 1'b1;
        i_dac_data = 16'hA5C3;
        chg_data   = 16'h0000;
        chg_en     = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check_eq("reset_dacdat", o_aud_dacdat, 0);
        check_eq("reset_ack", o_sample_ack, 0);
        check_eq("reset_busy", o_busy, 0);
        check_eq("reset_state", o_dbg_state, 0);
        i_rst = 1'b0;
        drive_bit(1'b1, d);
        drive_bit(1'b1, d);
        check_eq("idle_dacdat", d, 0);

        // Frame 1: A5C3 in 32-bit slots; 0, 16 data bits, 15 zeros
        exp_a5 = 64'h52E1_8000;
        run_frame(32, l, r, acks);
        check_eq("f1_left", l, exp_a5);
        check_eq("f1_right", r, stereo ? exp_a5 : 64'h0);
        check_eq("f1_acks", acks, 1);
        check_eq("f1_ack_latency", ack_cyc - fall_cyc, 3);
        check_eq("f1_busy_end", o_busy, 0);

        // Frame 2: sample changes mid-left slot; latched word still sent
        chg_bit  = 5;
        chg_data = 16'h8001;
        chg_en   = 1'b1;
        run_frame(32, l, r, acks);
        check_eq("f2_left", l, exp_a5);
        check_eq("f2_right", r, stereo ? exp_a5 : 64'h0);
        check_eq("f2_acks", acks, 1);

        // Frame 3: new sample 8001
        run_frame(32, l, r, acks);
        check_eq("f3_left", l, 64'h4000_8000);
        check_eq("f3_right", r, stereo ? 64'h4000_8000 : 64'h0);
        check_eq("f3_acks", acks, 1);

        // Short 12-bit slots with FFFF: delay bit then 11 ones, aborted by each slot start
        i_dac_data = 16'hFFFF;
        exp_short  = 64'h7FF;
        for (int k = 0; k < 2; k++) begin
            run_frame(12, l, r, acks);
            check_eq("short_left", l, exp_short);
            check_eq("short_right", r, stereo ? exp_short : 64'h0);
            check_eq("short_acks", acks, 1);
        end

        // Recovery to 32-bit slots
        i_dac_data = 16'hA5C3;
        run_frame(32, l, r, acks);
        check_eq("recover_left", l, exp_a5);
        check_eq("recover_acks", acks, 1);

        // Enable dropped mid-left: frame completes, next frame silent
        chg_bit  = 5;
        chg_data = 16'hA5C3;
        chg_en   = 1'b0;
        run_frame(32, l, r, acks);
        check_eq("en_drop_left", l, exp_a5);
        check_eq("en_drop_right", r, stereo ? exp_a5 : 64'h0);
        run_frame(32, l, r, acks);
        check_eq("en_off_left", l, 0);
        check_eq("en_off_right", r, 0);
        check_eq("en_off_acks", acks, 0);
        check_eq("en_off_busy", o_busy, 0);
        check_eq("en_off_state", o_dbg_state, 0);

        // Reset in the middle of SHIFT
        i_en = 1'b1;
        drive_bit(1'b0, d);
        drive_bit(1'b0, d);
        check_eq("rst_pre_bit", d, 1);
        check_eq("rst_pre_busy", o_busy, 1);
        #2;
        i_rst = 1'b1;
        #1;
        check_eq("rst_async_dacdat", o_aud_dacdat, 0);
        check_eq("rst_async_busy", o_busy, 0);
        check_eq("rst_async_ack", o_sample_ack, 0);
        check_eq("rst_async_state", o_dbg_state, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        a0  = ack_cnt;
        acc = 1'b0;
        for (int i = 2; i < 32; i++) begin
            drive_bit(1'b0, d);
            acc = acc | d;
        end
        for (int i = 0; i < 32; i++) begin
            drive_bit(1'b1, d);
            acc = acc | d;
        end
        check_eq("rst_silent_frame", acc, 0);
        check_eq("rst_no_ack", ack_cnt - a0, 0);
        run_frame(32, l, r, acks);
        check_eq("post_rst_left", l, exp_a5);
        check_eq("post_rst_acks", acks, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
